// File: rtl/axis_dual_frame_source.sv
// Dual AXI4-Stream ramp-frame source; beat k on both streams is {HI_WORDn, k}, and tlast is set on beat FRAME_LEN-1.
// Latency: first tvalid appears one cycle after enable is sampled; full rate is 1 beat/cycle per stream.
// Backpressure: each stream handshakes on its own, but the beat index advances only after both streams accept.
module axis_dual_frame_source #(
    parameter int          DATA_WIDTH = 64,
    parameter int          FRAME_LEN  = 1024,
    parameter int          GAP_CYCLES = 0,
    parameter logic [31:0] HI_WORD0   = 32'h0000_0002,
    parameter logic [31:0] HI_WORD1   = 32'h0000_0001
) (
    input  logic                    m00_axis_aclk,
    input  logic                    m00_axis_aresetn,
    input  logic                    enable,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                    m00_axis_tlast,
    output logic                    m00_axis_tvalid,
    input  logic                    m00_axis_tready,
    output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
    output logic                    m01_axis_tlast,
    output logic                    m01_axis_tvalid,
    input  logic                    m01_axis_tready,
    output logic                    busy,
    output logic [31:0]             frame_count
);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam logic [31:0] LAST_IDX = 32'(FRAME_LEN - 1);
    localparam logic [7:0]  GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t      state, state_nxt;
    logic [31:0] idx, idx_nxt;
    logic [7:0]  gap_cnt, gap_nxt;
    logic        acc0, acc0_nxt, acc1, acc1_nxt;
    logic        vld0, vld0_nxt, vld1, vld1_nxt;
    logic [31:0] fc_nxt;
    logic        hs0, hs1, done0, done1;

    assign hs0   = vld0 & m00_axis_tready;
    assign hs1   = vld1 & m01_axis_tready;
    assign done0 = acc0 | hs0;
    assign done1 = acc1 | hs1;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        gap_nxt   = gap_cnt;
        acc0_nxt  = acc0;
        acc1_nxt  = acc1;
        vld0_nxt  = vld0;
        vld1_nxt  = vld1;
        fc_nxt    = frame_count;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = SEND;
                    idx_nxt   = 32'd0;
                    vld0_nxt  = 1'b1;
                    vld1_nxt  = 1'b1;
                end
            end
            SEND: begin
                if (done0 && done1) begin
                    acc0_nxt = 1'b0;
                    acc1_nxt = 1'b0;
                    if (idx != LAST_IDX) begin
                        idx_nxt  = idx + 32'd1;
                        vld0_nxt = 1'b1;
                        vld1_nxt = 1'b1;
                    end else begin
                        fc_nxt  = frame_count + 32'd1;
                        idx_nxt = 32'd0;
                        gap_nxt = 8'd0;
                        if (GAP_CYCLES > 0) begin
                            state_nxt = GAP;
                            vld0_nxt  = 1'b0;
                            vld1_nxt  = 1'b0;
                        end else if (enable) begin
                            vld0_nxt = 1'b1;
                            vld1_nxt = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            vld0_nxt  = 1'b0;
                            vld1_nxt  = 1'b0;
                        end
                    end
                end else begin
                    // A stream that has taken the beat goes quiet until its partner catches up.
                    acc0_nxt = done0;
                    acc1_nxt = done1;
                    vld0_nxt = vld0 & ~hs0;
                    vld1_nxt = vld1 & ~hs1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    idx_nxt = 32'd0;
                    if (enable) begin
                        state_nxt = SEND;
                        vld0_nxt  = 1'b1;
                        vld1_nxt  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    gap_nxt = gap_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state       <= IDLE;
            idx         <= 32'd0;
            gap_cnt     <= 8'd0;
            acc0        <= 1'b0;
            acc1        <= 1'b0;
            vld0        <= 1'b0;
            vld1        <= 1'b0;
            frame_count <= 32'd0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            gap_cnt     <= gap_nxt;
            acc0        <= acc0_nxt;
            acc1        <= acc1_nxt;
            vld0        <= vld0_nxt;
            vld1        <= vld1_nxt;
            frame_count <= fc_nxt;
            busy        <= (state_nxt != IDLE);
        end
    end

    // Outputs decode from registers only, so tvalid never depends on tready within a cycle.
    assign m00_axis_tvalid = vld0;
    assign m01_axis_tvalid = vld1;
    assign m00_axis_tlast  = vld0 & (idx == LAST_IDX);
    assign m01_axis_tlast  = vld1 & (idx == LAST_IDX);
    assign m00_axis_tdata  = (state == SEND) ? {HI_WORD0, idx} : '0;
    assign m01_axis_tdata  = (state == SEND) ? {HI_WORD1, idx} : '0;
    assign m00_axis_tstrb  = '1;
    assign m01_axis_tstrb  = '1;
endmodule

// File: tb/tb_axis_dual_frame_source.sv
// Directed bench: a 1024-beat gapless source driven through skew, random backpressure, enable drop and
// async reset, and an 8-beat source with a 4-cycle inter-frame gap.
module tb_axis_dual_frame_source;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, rdy0, rdy1;
    logic [63:0] tdata0, tdata1;
    logic [7:0]  tstrb0, tstrb1;
    logic        tlast0, tlast1, vld0, vld1, busy;
    logic [31:0] fc;

    logic        g_en;
    logic        g_rdy0 = 1'b1;
    logic        g_rdy1 = 1'b1;
    logic [63:0] g_tdata0, g_tdata1;
    logic [7:0]  g_tstrb0, g_tstrb1;
    logic        g_tlast0, g_tlast1, g_vld0, g_vld1, g_busy;
    logic [31:0] g_fc;

    int checks = 0;
    int errors = 0;
    logic [31:0] e0, e1;
    int last_cnt0, last_cnt1;

    always #5 clk = ~clk;

    axis_dual_frame_source #(.DATA_WIDTH(64), .FRAME_LEN(1024), .GAP_CYCLES(0)) dut (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .enable(en),
        .m00_axis_tdata(tdata0), .m00_axis_tstrb(tstrb0), .m00_axis_tlast(tlast0),
        .m00_axis_tvalid(vld0), .m00_axis_tready(rdy0),
        .m01_axis_tdata(tdata1), .m01_axis_tstrb(tstrb1), .m01_axis_tlast(tlast1),
        .m01_axis_tvalid(vld1), .m01_axis_tready(rdy1),
        .busy(busy), .frame_count(fc)
    );

    axis_dual_frame_source #(.DATA_WIDTH(64), .FRAME_LEN(8), .GAP_CYCLES(4)) dut_g (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .enable(g_en),
        .m00_axis_tdata(g_tdata0), .m00_axis_tstrb(g_tstrb0), .m00_axis_tlast(g_tlast0),
        .m00_axis_tvalid(g_vld0), .m00_axis_tready(g_rdy0),
        .m01_axis_tdata(g_tdata1), .m01_axis_tstrb(g_tstrb1), .m01_axis_tlast(g_tlast1),
        .m01_axis_tvalid(g_vld1), .m01_axis_tready(g_rdy1),
        .busy(g_busy), .frame_count(g_fc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference ramp per stream: every accepted beat must be the next index in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            e0 = 32'd0;
            e1 = 32'd0;
        end else begin
            if (vld0 && rdy0) begin
                chk("s0_data", tdata0, {32'h0000_0002, e0});
                chk("s0_last", {63'd0, tlast0}, {63'd0, (e0 == 32'd1023)});
                if (tlast0) last_cnt0++;
                e0 = (e0 == 32'd1023) ? 32'd0 : e0 + 32'd1;
            end
            if (vld1 && rdy1) begin
                chk("s1_data", tdata1, {32'h0000_0001, e1});
                chk("s1_last", {63'd0, tlast1}, {63'd0, (e1 == 32'd1023)});
                if (tlast1) last_cnt1++;
                e1 = (e1 == 32'd1023) ? 32'd0 : e1 + 32'd1;
            end
        end
    end

    initial begin
        int cyc;
        rst_n = 1'b0; en = 1'b0; g_en = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
        last_cnt0 = 0; last_cnt1 = 0;
        #3;
        chk("rst_vld0", {63'd0, vld0}, 64'd0);
        chk("rst_vld1", {63'd0, vld1}, 64'd0);
        chk("rst_last0", {63'd0, tlast0}, 64'd0);
        chk("rst_data0", tdata0, 64'd0);
        chk("rst_data1", tdata1, 64'd0);
        chk("rst_fc", {32'd0, fc}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        tick();
        chk("idle_vld0", {63'd0, vld0}, 64'd0);

        // Full-rate frame, then back-to-back restart.
        en = 1'b1;
        tick();
        chk("first_data0", tdata0, 64'h0000_0002_0000_0000);
        chk("first_data1", tdata1, 64'h0000_0001_0000_0000);
        chk("first_vld", {62'd0, vld0, vld1}, 64'd3);
        chk("first_busy", {63'd0, busy}, 64'd1);
        repeat (1023) tick();
        chk("f1_last_data", tdata0, 64'h0000_0002_0000_03FF);
        chk("f1_tlast", {62'd0, tlast0, tlast1}, 64'd3);
        tick();
        chk("f2_restart", tdata0, 64'h0000_0002_0000_0000);
        chk("f2_nobubble", {62'd0, vld0, vld1}, 64'd3);
        chk("f2_tlast", {63'd0, tlast0}, 64'd0);
        chk("fc_1", {32'd0, fc}, 64'd1);

        // Stream 1 stalls on beat 10 while stream 0 has taken it.
        repeat (10) tick();
        chk("skew_beat10", tdata1, 64'h0000_0001_0000_000A);
        rdy1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("skew_vld0_low", {63'd0, vld0}, 64'd0);
            chk("skew_hold1", {vld1, tdata1[62:0]}, {1'b1, 63'h0000_0001_0000_000A});
        end
        rdy1 = 1'b1;
        tick();
        chk("skew_beat11_0", {vld0, tdata0[62:0]}, {1'b1, 63'h0000_0002_0000_000B});
        chk("skew_beat11_1", {vld1, tdata1[62:0]}, {1'b1, 63'h0000_0001_0000_000B});

        // Independent random backpressure for the rest of frame 2 plus frames 3 and 4.
        last_cnt0 = 0; last_cnt1 = 0;
        cyc = 0;
        while (fc != 32'd4 && cyc < 20000) begin
            rdy0 = 1'($urandom_range(0, 1));
            rdy1 = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        if (cyc >= 20000) chk("rand_timeout", 64'd0, 64'd1);
        rdy0 = 1'b1; rdy1 = 1'b1;
        chk("rand_tlast0", 64'(last_cnt0), 64'd3);
        chk("rand_tlast1", 64'(last_cnt1), 64'd3);
        chk("rand_fc", {32'd0, fc}, 64'd4);
        chk("rand_next0", {vld0, tdata0[62:0]}, {1'b1, 63'h0000_0002_0000_0000});

        // Dropping enable mid-frame lets the frame finish, then idles.
        repeat (100) tick();
        chk("en_beat100", tdata0, 64'h0000_0002_0000_0064);
        en = 1'b0;
        repeat (923) tick();
        chk("en_lastbeat", {tlast0, tdata0[62:0]}, {1'b1, 63'h0000_0002_0000_03FF});
        tick();
        chk("en_idle_busy", {63'd0, busy}, 64'd0);
        chk("en_idle_vld", {62'd0, vld0, vld1}, 64'd0);
        chk("en_fc", {32'd0, fc}, 64'd5);
        repeat (3) tick();
        chk("en_stay_idle", {62'd0, vld0, vld1}, 64'd0);

        // Asynchronous reset in the middle of a frame.
        en = 1'b1;
        tick();
        repeat (500) tick();
        chk("ar_beat500", tdata0, 64'h0000_0002_0000_01F4);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_vld", {62'd0, vld0, vld1}, 64'd0);
        chk("ar_tlast", {62'd0, tlast0, tlast1}, 64'd0);
        chk("ar_fc", {32'd0, fc}, 64'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        tick();
        chk("ar_restart", {vld0, tdata0[62:0]}, {1'b1, 63'h0000_0002_0000_0000});
        chk("ar_restart1", {vld1, tdata1[62:0]}, {1'b1, 63'h0000_0001_0000_0000});

        // Inter-frame gap of 4 cycles on the short-frame instance.
        g_en = 1'b1;
        tick();
        chk("gap_first", {g_vld0, g_tdata0[62:0]}, {1'b1, 63'h0000_0002_0000_0000});
        repeat (7) tick();
        chk("gap_last", {g_tlast0, g_tdata0[62:0]}, {1'b1, 63'h0000_0002_0000_0007});
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("gap_idle_vld", {62'd0, g_vld0, g_vld1}, 64'd0);
            chk("gap_busy", {63'd0, g_busy}, 64'd1);
        end
        tick();
        chk("gap_restart", {g_vld1, g_tdata1[62:0]}, {1'b1, 63'h0000_0001_0000_0000});
        chk("gap_fc", {32'd0, g_fc}, 64'd1);
        g_en = 1'b0;
        en = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
